hazard_unit_md: RTL
===================

Name: hazard_unit_md

Overview:
- Parametrised forwarding/stall controller for the 5-stage pipeline (F/D/E/M/W).
- Forwarding-select and Tuse/Tnew stall logic are combinational.
- Adds a sequential multiply/divide busy tracker (HI/LO unit) that stalls D-stage HI/LO users while an operation is in flight.
- Sits beside the datapath; drives the D-stage comparator muxes, E-stage ALU muxes, M-stage DM write-data mux, and the F/D freeze / E flush.

Parameters:
- REG_AW, 5, register address width; register 0 is never forwarded and never stalls.
- T_W, 3, width of Tuse/Tnew fields.
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.
- CNT_W, 4, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock (single clock domain).
- reset  in  1  synchronous, active-high reset.
- a1_d, a2_d  in  REG_AW  rs/rt read addresses in D.
- a1_e, a2_e  in  REG_AW  rs/rt read addresses in E.
- a2_m  in  REG_AW  rt read address in M.
- a3_e, a3_m, a3_w  in  REG_AW  destination addresses in E/M/W.
- we_e, we_m, we_w  in  1  GRF write enable per stage.
- tuse_rs, tuse_rt  in  T_W  D-stage operand use times.
- tnew_e, tnew_m  in  T_W  result-ready times in E/M.
- md_start_e  in  1  mult/div starts in E this cycle.
- md_is_div_e  in  1  1=div, 0=mult; valid with md_start_e.
- md_use_d  in  1  D instruction is mfhi/mflo/mthi/mtlo/mult/div.
- fw_cmp_rs, fw_cmp_rt  out  2  comparator source: 3=E, 2=M, 1=W, 0=D.
- fw_alu_rs, fw_alu_rt  out  2  ALU source: 2=M, 1=W, 0=E.
- fw_dm_rt  out  1  DM write data: 1=W, 0=M.
- stall  out  1  freeze F/D, flush E.
- md_busy  out  1  HI/LO unit busy.
- stall_cnt  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Forward match: read addr == dest addr, dest addr != 0, and stage we set. Priority E > M > W for comparator selects; M > W for ALU selects. No match selects the local value (code 0).
- Tuse/Tnew stall term per (operand, stage) for E and M: (tuse < tnew) && addr != 0 && addr == a3_x && we_x.
- md_cnt register, CNT_W bits, reset to 0.
  - Reset has priority over every other update.
  - md_start_e=1: md_cnt loads DIV_CYCLES if md_is_div_e, else MULT_CYCLES. A start while busy reloads (restart).
  - Otherwise, if md_cnt != 0: md_cnt decrements by 1 per cycle. md_cnt saturates at 0 and never wraps.
- md_busy = (md_cnt != 0); registered, 0 out of reset.
- md_stall = md_use_d && (md_start_e || md_busy). Start and use in the same cycle stall.
- stall = OR of all Tuse/Tnew terms OR md_stall. Purely combinational from inputs and md_cnt.
- Reset values: md_busy=0, stall_cnt=0. Combinational outputs follow their inputs during reset, except md_stall uses md_cnt=0.
- Latency: a mult started at cycle t keeps md_busy=1 for cycles t+1..t+MULT_CYCLES.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt increments on every cycle with stall=1, resets to 0, and wraps at 2^32.
- Undefined: stall_cnt tied to 0 and no counter flops are synthesised. The port is present in both builds.

Decomposition:
- Shared package (hazard_pkg): forwarding select encodings (CMP_FROM_E/M/W/D, ALU_FROM_M/W/E, DM_FROM_W/M) and default cycle counts.
- One sub-module, md_busy_tracker: counter, load/decrement logic and md_busy.
- Forwarding and stall logic stay in the top module.

Test Plan:
- a1_d=5, a3_e=5, we_e=1, a3_m=5, we_m=1 -> fw_cmp_rs=3. Same with a3_e=0 -> fw_cmp_rs=2.
- a2_e=0, a3_m=0, we_m=1 -> fw_alu_rt=0 (register 0 is not forwarded).
- lw-use: tuse_rs=1, tnew_e=2, a1_d=a3_e=8, we_e=1 -> stall=1. Next cycle with tnew_m=1 -> stall=0.
- md_start_e=1, md_is_div_e=1 at t; md_use_d=1 held -> stall=1 for cycles t..t+10, 0 at t+11.
- Mult start, then reset at t+2 -> md_busy=0 at t+3, stall=0 with md_use_d=1.
- With HAZARD_PERF_CNT_EN defined, 3 stall cycles -> stall_cnt=3. With the macro undefined -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg : shared select encodings and default mult/div latencies
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

  // D-stage comparator operand source
  typedef enum logic [1:0] {
    CMP_FROM_D = 2'd0,
    CMP_FROM_W = 2'd1,
    CMP_FROM_M = 2'd2,
    CMP_FROM_E = 2'd3
  } cmp_sel_e;

  // E-stage ALU operand source
  typedef enum logic [1:0] {
    ALU_FROM_E = 2'd0,
    ALU_FROM_W = 2'd1,
    ALU_FROM_M = 2'd2
  } alu_sel_e;

  // M-stage data-memory write data source
  typedef enum logic {
    DM_FROM_M = 1'b0,
    DM_FROM_W = 1'b1
  } dm_sel_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int DEF_CNT_W       = 4;

endpackage : hazard_pkg

`default_nettype wire

// File: rtl/md_busy_tracker.sv
// ---------------------------------------------------------------------------
// md_busy_tracker : HI/LO unit occupancy counter (load on start, count down)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // A start always reloads, so a restart while busy extends the busy window.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (start) begin
      w_cnt_nxt = is_div ? C_DIV_LOAD : C_MULT_LOAD;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign busy = (r_cnt != '0);

endmodule : md_busy_tracker

`default_nettype wire

// File: rtl/hazard_unit_md.sv
// ---------------------------------------------------------------------------
// hazard_unit_md : 5-stage forwarding/stall controller with HI/LO busy stall
// Optional stall-cycle counter enabled by macro HAZARD_PERF_CNT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_unit_md
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int T_W         = 3,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] a1_d,
  input  logic [REG_AW-1:0] a2_d,
  input  logic [REG_AW-1:0] a1_e,
  input  logic [REG_AW-1:0] a2_e,
  input  logic [REG_AW-1:0] a2_m,
  input  logic [REG_AW-1:0] a3_e,
  input  logic [REG_AW-1:0] a3_m,
  input  logic [REG_AW-1:0] a3_w,
  input  logic              we_e,
  input  logic              we_m,
  input  logic              we_w,
  input  logic [T_W-1:0]    tuse_rs,
  input  logic [T_W-1:0]    tuse_rt,
  input  logic [T_W-1:0]    tnew_e,
  input  logic [T_W-1:0]    tnew_m,
  input  logic              md_start_e,
  input  logic              md_is_div_e,
  input  logic              md_use_d,
  output logic [1:0]        fw_cmp_rs,
  output logic [1:0]        fw_cmp_rt,
  output logic [1:0]        fw_alu_rs,
  output logic [1:0]        fw_alu_rt,
  output logic              fw_dm_rt,
  output logic              stall,
  output logic              md_busy,
  output logic [31:0]       stall_cnt
);

  // Register 0 is hardwired; a write to it is never a producer.
  function automatic logic fwd_hit(input logic [REG_AW-1:0] addr,
                                   input logic [REG_AW-1:0] dst,
                                   input logic              we);
    return we && (addr != '0) && (addr == dst);
  endfunction

  function automatic logic [1:0] cmp_sel(input logic [REG_AW-1:0] addr);
    cmp_sel_e sel;
    if (fwd_hit(addr, a3_e, we_e))      sel = CMP_FROM_E;
    else if (fwd_hit(addr, a3_m, we_m)) sel = CMP_FROM_M;
    else if (fwd_hit(addr, a3_w, we_w)) sel = CMP_FROM_W;
    else                                sel = CMP_FROM_D;
    return sel;
  endfunction

  function automatic logic [1:0] alu_sel(input logic [REG_AW-1:0] addr);
    alu_sel_e sel;
    if (fwd_hit(addr, a3_m, we_m))      sel = ALU_FROM_M;
    else if (fwd_hit(addr, a3_w, we_w)) sel = ALU_FROM_W;
    else                                sel = ALU_FROM_E;
    return sel;
  endfunction

  // ---------------------------------------------------------------- forwarding
  always_comb begin
    fw_cmp_rs = cmp_sel(a1_d);
    fw_cmp_rt = cmp_sel(a2_d);
    fw_alu_rs = alu_sel(a1_e);
    fw_alu_rt = alu_sel(a2_e);
    fw_dm_rt  = fwd_hit(a2_m, a3_w, we_w) ? DM_FROM_W : DM_FROM_M;
  end

  // ---------------------------------------------------------- Tuse/Tnew stall
  logic w_stall_rs_e;
  logic w_stall_rs_m;
  logic w_stall_rt_e;
  logic w_stall_rt_m;
  logic w_tt_stall;

  always_comb begin
    w_stall_rs_e = (tuse_rs < tnew_e) && fwd_hit(a1_d, a3_e, we_e);
    w_stall_rs_m = (tuse_rs < tnew_m) && fwd_hit(a1_d, a3_m, we_m);
    w_stall_rt_e = (tuse_rt < tnew_e) && fwd_hit(a2_d, a3_e, we_e);
    w_stall_rt_m = (tuse_rt < tnew_m) && fwd_hit(a2_d, a3_m, we_m);
    w_tt_stall   = w_stall_rs_e | w_stall_rs_m | w_stall_rt_e | w_stall_rt_m;
  end

  // ------------------------------------------------------------- HI/LO busy
  logic w_md_busy;
  logic w_md_stall;

  md_busy_tracker #(
    .CNT_W       (CNT_W),
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_tracker (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_e),
    .is_div (md_is_div_e),
    .busy   (w_md_busy)
  );

  assign md_busy = w_md_busy;

  // While reset is asserted the counter is treated as already cleared.
  assign w_md_stall = md_use_d && (md_start_e || (w_md_busy && !reset));
  assign stall      = w_tt_stall || w_md_stall;

  // ----------------------------------------------------- stall-cycle counter
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule : hazard_unit_md

`default_nettype wire
